// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: FSM state encoding, RV32I
// width codes, the latched request record and the request legality check.
package lsu_pkg;

   // FSM state encoding
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RD      = 3'd1;
   localparam logic [2:0] ST_RD_WAIT = 3'd2;
   localparam logic [2:0] ST_WR      = 3'd3;
   localparam logic [2:0] ST_RESP    = 3'd4;

   // RV32I funct3 width codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Request fields captured on acceptance
   typedef struct packed {
      logic        write;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
   } lsu_req_t;

   // 1 when the request must be rejected without touching memory:
   // misaligned halfword/word, reserved width code, or unsigned width on a store.
   function automatic logic lsu_reject(input logic [2:0] funct3,
                                       input logic       write,
                                       input logic [1:0] byte_off);
      logic bad;
      case (funct3)
         F3_B:    bad = 1'b0;
         F3_H:    bad = byte_off[0];
         F3_W:    bad = (byte_off != 2'b00);
         F3_BU:   bad = write;
         F3_HU:   bad = write | byte_off[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: load lane select with sign/zero extension,
// and merge of sub-word store data into the word read back from memory.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Pick the addressed lane and format the load result
   always_comb begin
      byte_lane = rdata[{byte_off, 3'b000} +: 8];
      half_lane = byte_off[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
         F3_BU:   load_data = {24'h000000, byte_lane};
         F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
         F3_HU:   load_data = {16'h0000, half_lane};
         default: load_data = rdata;
      endcase
   end

   // Overlay the store bytes on the read word, leaving other lanes untouched
   always_comb begin
      merged = rdata;
      case (funct3)
         F3_B: merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
         F3_H: begin
            if (byte_off[1]) merged[31:16] = wdata[15:0];
            else             merged[15:0]  = wdata[15:0];
         end
         default: merged = wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a core request port and a
// one-cycle-latency word memory. Sub-word stores use read-modify-write.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 256
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_misaligned,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] endereco,
   output logic [31:0] write_data,
   input  logic [31:0] read_data
);

   localparam logic [29:0] DEPTH = 30'(MEM_WORDS);

   logic [2:0]  state;
   lsu_req_t    req_q;
   logic [31:0] load_data;
   logic [31:0] merged;
   logic [29:0] word_idx;

   lsu_align u_align (
      .funct3    (req_q.funct3),
      .byte_off  (req_q.addr[1:0]),
      .rdata     (read_data),
      .wdata     (req_q.wdata),
      .load_data (load_data),
      .merged    (merged)
   );

   // Memory strobes decode straight from state, so they drop the cycle after reset
   always_comb begin
      word_idx   = req_q.addr[31:2] % DEPTH;
      endereco   = {2'b00, word_idx};
      write_data = req_q.wdata;
      req_ready  = (state == ST_IDLE);
      mem_read   = (state == ST_RD);
      mem_write  = (state == ST_WR);
   end

   // Sequencer: accept, access memory, then emit a one-cycle registered response
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         req_q           <= '0;
         resp_valid      <= 1'b0;
         resp_misaligned <= 1'b0;
         resp_rdata      <= 32'h0;
      end else begin
         resp_valid      <= 1'b0;
         resp_misaligned <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  req_q.write  <= req_write;
                  req_q.funct3 <= req_funct3;
                  req_q.addr   <= req_addr;
                  req_q.wdata  <= req_wdata;
                  if (lsu_reject(req_funct3, req_write, req_addr[1:0])) begin
                     state           <= ST_RESP;
                     resp_valid      <= 1'b1;
                     resp_misaligned <= 1'b1;
                     resp_rdata      <= 32'h0;
                  end else if (req_write && req_funct3 == F3_W) begin
                     state <= ST_WR;
                  end else begin
                     // loads and sub-word stores both start with a read
                     state <= ST_RD;
                  end
               end
            end
            ST_RD: state <= ST_RD_WAIT;
            ST_RD_WAIT: begin
               if (req_q.write) begin
                  req_q.wdata <= merged;
                  state       <= ST_WR;
               end else begin
                  resp_rdata <= load_data;
                  resp_valid <= 1'b1;
                  state      <= ST_RESP;
               end
            end
            ST_WR: begin
               resp_rdata <= 32'h0;
               resp_valid <= 1'b1;
               state      <= ST_RESP;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a one-cycle-latency memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_misaligned;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] endereco;
   logic [31:0] write_data;
   logic [31:0] read_data;

   logic [31:0] mem [0:255];

   int passed = 0;
   int total  = 0;

   int          lat, nrd, nwr;
   logic [31:0] rdata, waddr, wdata;
   logic        mis;
   int          stray_wr;

   load_store_unit #(.MEM_WORDS(256)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_write       (req_write),
      .req_funct3      (req_funct3),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata),
      .resp_misaligned (resp_misaligned),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .endereco        (endereco),
      .write_data      (write_data),
      .read_data       (read_data)
   );

   always #5 clk = ~clk;

   // Word memory: synchronous write, read data valid the cycle after mem_read
   always @(posedge clk) begin
      if (mem_write) mem[endereco[7:0]] <= write_data;
      if (mem_read)  read_data <= mem[endereco[7:0]];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Issue one request and follow it until resp_valid (bounded), then back to IDLE
   task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output int l, output logic [31:0] rd,
                         output logic m, output int nr, output int nw,
                         output logic [31:0] wa, output logic [31:0] wd);
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
      tick();
      req_valid = 1'b0;
      l = 0; nr = 0; nw = 0; rd = 'x; m = 1'bx; wa = 'x; wd = 'x;
      for (int i = 1; i <= 10; i++) begin
         if (mem_read) nr++;
         if (mem_write) begin nw++; wa = endereco; wd = write_data; end
         if (resp_valid) begin
            l = i; rd = resp_rdata; m = resp_misaligned;
            break;
         end
         tick();
      end
      tick();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0] = 32'hA5A5_0001;
      mem[5] = 32'h8000_00F0;
      mem[9] = 32'h1111_2222;
      read_data = 32'h0;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0;
      tick(); tick();
      check("rst_ready", {31'b0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_resp_mis", {31'b0, resp_misaligned}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
      rst_n = 1'b1;
      tick();

      // LB with cycle-by-cycle timing
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b000; req_addr = 32'h14;
      tick();
      req_valid = 1'b0;
      check("lb_t1_rd", {30'b0, mem_read, mem_write}, 32'd2);
      check("lb_t1_addr", endereco, 32'd5);
      check("lb_t1_ready", {31'b0, req_ready}, 32'd0);
      tick();
      check("lb_t2_rd", {30'b0, mem_read, resp_valid}, 32'd0);
      tick();
      check("lb_t3_valid", {31'b0, resp_valid}, 32'd1);
      check("lb_t3_rdata", resp_rdata, 32'hFFFF_FFF0);
      check("lb_t3_mis", {31'b0, resp_misaligned}, 32'd0);
      tick();
      check("lb_t4_idle", {30'b0, resp_valid, req_ready}, 32'd1);

      run_op(1'b0, 3'b100, 32'h14, 32'h0, lat, rdata, mis, nrd, nwr, waddr, wdata);
      check("lbu_rdata", rdata, 32'h0000_00F0);
      check("lbu_lat", lat, 3);

      run_op(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, lat, rdata, mis, nrd, nwr, waddr, wdata);
      check("sw_lat", lat, 2);
      check("sw_strobes", {nrd[15:0], nwr[15:0]}, 32'h0000_0001);
      check("sw_endereco", waddr, 32'd8);
      check("sw_wdata", wdata, 32'hDEAD_BEEF);
      check("sw_rdata", rdata, 32'h0);

      run_op(1'b0, 3'b010, 32'h20, 32'h0, lat, rdata, mis, nrd, nwr, waddr, wdata);
      check("lw_rdata", rdata, 32'hDEAD_BEEF);
      check("lw_lat", lat, 3);

      run_op(1'b1, 3'b000, 32'h22, 32'h0000_0055, lat, rdata, mis, nrd, nwr, waddr, wdata);
      check("sb_lat", lat, 4);
      check("sb_strobes", {nrd[15:0], nwr[15:0]}, 32'h0001_0001);
      check("sb_merged", wdata, 32'hDE55_BEEF);

      run_op(1'b0, 3'b010, 32'h20, 32'h0, lat, rdata, mis, nrd, nwr, waddr, wdata);
      check("lw_after_sb", rdata, 32'hDE55_BEEF);

      run_op(1'b0, 3'b001, 32'h21, 32'h0, lat, rdata, mis, nrd, nwr, waddr, wdata);
      check("lh_mis_lat", lat, 1);
      check("lh_mis_flag", {31'b0, mis}, 32'd1);
      check("lh_mis_rdata", rdata, 32'h0);
      check("lh_mis_strobes", {nrd[15:0], nwr[15:0]}, 32'h0);

      run_op(1'b0, 3'b001, 32'h16, 32'h0, lat, rdata, mis, nrd, nwr, waddr, wdata);
      check("lh_hi", rdata, 32'hFFFF_8000);
      run_op(1'b0, 3'b101, 32'h16, 32'h0, lat, rdata, mis, nrd, nwr, waddr, wdata);
      check("lhu_hi", rdata, 32'h0000_8000);
      run_op(1'b0, 3'b001, 32'h14, 32'h0, lat, rdata, mis, nrd, nwr, waddr, wdata);
      check("lh_lo", rdata, 32'h0000_00F0);
      check("lh_lo_mis", {31'b0, mis}, 32'd0);

      run_op(1'b0, 3'b011, 32'h20, 32'h0, lat, rdata, mis, nrd, nwr, waddr, wdata);
      check("illegal_f3_mis", {31'b0, mis}, 32'd1);
      check("illegal_f3_lat", lat, 1);
      run_op(1'b1, 3'b100, 32'h20, 32'h77, lat, rdata, mis, nrd, nwr, waddr, wdata);
      check("sbu_store_mis", {31'b0, mis}, 32'd1);
      check("sbu_store_nowr", nwr, 0);

      // Reset during RD_WAIT of an SH aborts it
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001; req_addr = 32'h20;
      req_wdata = 32'h0000_1234;
      tick();
      req_valid = 1'b0;
      check("sh_rd", {31'b0, mem_read}, 32'd1);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_ready", {31'b0, req_ready}, 32'd1);
      check("abort_resp", {31'b0, resp_valid}, 32'd0);
      stray_wr = 0;
      for (int i = 0; i < 4; i++) begin
         if (mem_write || resp_valid) stray_wr++;
         tick();
      end
      check("abort_quiet", stray_wr, 0);
      check("abort_mem", mem[8], 32'hDE55_BEEF);

      // req_valid held through two LWs; first address wraps to word 0
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
      tick();
      req_addr = 32'h24;
      check("b2b_wrap_addr", endereco, 32'd0);
      check("b2b_busy_ready", {31'b0, req_ready}, 32'd0);
      tick(); tick();
      check("b2b_first_valid", {31'b0, resp_valid}, 32'd1);
      check("b2b_first_rdata", resp_rdata, 32'hA5A5_0001);
      tick();
      check("b2b_ready_after", {31'b0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      check("b2b_second_rd", {31'b0, mem_read}, 32'd1);
      check("b2b_second_addr", endereco, 32'd9);
      tick(); tick();
      check("b2b_second_valid", {31'b0, resp_valid}, 32'd1);
      check("b2b_second_rdata", resp_rdata, 32'h1111_2222);
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, data-memory depth in 32-bit words; word index wraps modulo MEM_WORDS.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  core request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_write  input  1  1=store, 0=load.
REQ-007 SHALL have port req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  formatted load data; 0 for stores and errors.
REQ-012 SHALL have port resp_misaligned  output  1  request rejected: misaligned or illegal funct3.
REQ-013 SHALL have ports mem_read  output  1, mem_write  output  1, endereco  output  32 (word index = req_addr[31:2] mod MEM_WORDS), write_data  output  32, read_data  input  32: data-memory initiator side; read_data valid in the cycle after mem_read.

Function
REQ-014 SHALL implement FSM states IDLE, RD, RD_WAIT, WR, RESP; req_ready=1 only in IDLE.
REQ-015 SHALL accept a request on an edge where state=IDLE and req_valid=1, latching all req_* fields.
REQ-016 SHALL drive mem_read=1 only in RD, mem_write=1 only in WR; never both; endereco/write_data held stable for that cycle.
REQ-017 Load (accepted edge T): RD in cycle T+1, RD_WAIT T+2 (capture read_data), RESP T+3 with resp_valid=1.
REQ-018 SW: WR in T+1 with write_data=req_wdata, RESP T+2.
REQ-019 SB/SH: read-modify-write: RD T+1, RD_WAIT T+2 (merge store bytes into read word at lane addr[1:0]/addr[1]), WR T+3, RESP T+4; other bytes unchanged.
REQ-020 LB/LH SHALL sign-extend, LBU/LHU zero-extend, selected lane per addr[1:0]; LW returns word unchanged.
REQ-021 Misaligned (H with addr[0]=1, W with addr[1:0]!=0) or illegal funct3 (011,110,111; 100/101 on store) SHALL skip memory access, go IDLE->RESP, resp_valid in T+1 with resp_misaligned=1, resp_rdata=0.
REQ-022 RESP SHALL last exactly one cycle then return to IDLE; no response backpressure; back-to-back request accepted the cycle after RESP.
REQ-023 resp_valid/resp_misaligned/resp_rdata SHALL be registered; resp_misaligned=0 for successful accesses.
REQ-024 req_valid while not IDLE SHALL be ignored (no queueing).

Reset
REQ-025 On rst_n=0 at an edge: state=IDLE, resp_valid=0, resp_misaligned=0, resp_rdata=0, latched request cleared; mem_read=mem_write=0 from the next cycle.
REQ-026 Reset mid-operation SHALL abort it with no response; a strobe asserted in the reset cycle may complete at that edge, no later strobe issued.

Structure
REQ-027 SHALL place FSM state encoding and funct3 width constants in shared package lsu_pkg.
REQ-028 SHALL use one combinational sub-module lsu_align for lane select, sign/zero extension and store-byte merge.

Verification
REQ-029 Preload word 5 = 0x8000_00F0; LB addr 0x14 -> resp_valid at T+3, resp_rdata=0xFFFF_FFF0; LBU -> 0x0000_00F0.
REQ-030 SW addr 0x20 data 0xDEAD_BEEF -> mem_write at T+1, endereco=8, resp at T+2; LW 0x20 returns 0xDEAD_BEEF.
REQ-031 Word 8 = 0xDEAD_BEEF; SB addr 0x22 data 0x55 -> RMW, resp at T+4; LW 0x20 returns 0xDE55_BEEF.
REQ-032 LH addr 0x21 -> no mem_read/mem_write, resp_valid at T+1, resp_misaligned=1, resp_rdata=0.
REQ-033 rst_n=0 during RD_WAIT of an SH -> no mem_write, no resp_valid, req_ready=1 next cycle; memory word unchanged.
REQ-034 req_valid held high for two LWs -> second accepted the cycle after first RESP; addr 0x400 maps to endereco=0 (wrap, MEM_WORDS=256).
